// File: rtl/timer_device.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_device : memory-mapped countdown timer driving one external IRQ bit  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module timer_device #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        writeEnable,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               ctrl_q, ctrl_d;
  logic [COUNTER_WIDTH-1:0] preset_q, preset_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     irq_pending_q, irq_pending_d;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic        periodic;
  logic [31:0] preset_rd;
  logic [31:0] count_rd;

  assign wr_ctrl   = writeEnable && (address == ADDR_CTRL);
  assign wr_preset = writeEnable && (address == ADDR_PRESET);
  assign ctrl_en   = ctrl_q[0];
  assign periodic  = (ctrl_q[2:1] == MODE_PERIODIC);

  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    preset_d      = preset_q;
    count_d       = count_q;
    irq_pending_d = irq_pending_q;

    case (state_q)
      IDLE: begin
        if (ctrl_en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        if (periodic) irq_pending_d = 1'b0;
        state_d = CNT;
      end
      CNT: begin
        // A count of 0 or 1 both expire, so PRESET = 0 behaves like 1.
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else begin
          count_d = '0;
          state_d = INT;
        end
      end
      INT: begin
        irq_pending_d = 1'b1;
        if (periodic) begin
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes are applied last so they override the FSM's EN clear.
    if (wr_ctrl)   ctrl_d   = writeData[3:0];
    if (wr_preset) preset_d = writeData[COUNTER_WIDTH-1:0];
    if (wr_ctrl || wr_preset) irq_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      ctrl_q        <= '0;
      preset_q      <= '0;
      count_q       <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      preset_q      <= preset_d;
      count_q       <= count_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  always_comb begin
    preset_rd                      = '0;
    preset_rd[COUNTER_WIDTH-1:0]   = preset_q;
    count_rd                       = '0;
    count_rd[COUNTER_WIDTH-1:0]    = count_q;
  end

  always_comb begin
    readData = '0;
    case (address)
      ADDR_CTRL:   readData = {28'd0, ctrl_q};
      ADDR_PRESET: readData = preset_rd;
      ADDR_COUNT:  readData = count_rd;
      default:     readData = '0;
    endcase
  end

  assign irq = irq_pending_q & ctrl_q[3];

endmodule
`default_nettype wire

// File: tb/tb_timer_device.sv
`default_nettype none
// Directed self-checking bench for timer_device: reset, one-shot, periodic,
// masking, disable and width/address boundaries with hand-computed values.
module tb_timer_device;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        writeEnable;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        irq;

  logic [1:0]  addr8;
  logic        we8;
  logic [31:0] wd8;
  logic [31:0] rd8;
  logic        irq8;

  int n_tests = 0;
  int n_fail  = 0;

  timer_device dut (
    .clk(clk), .reset(reset), .address(address), .writeEnable(writeEnable),
    .writeData(writeData), .readData(readData), .irq(irq)
  );

  timer_device #(.COUNTER_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .address(addr8), .writeEnable(we8),
    .writeData(wd8), .readData(rd8), .irq(irq8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address     = a;
    writeData   = d;
    writeEnable = 1'b1;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readData;
  endtask

  logic [31:0] v;
  logic        exp_irq;

  initial begin
    reset = 1'b0; address = 2'd0; writeData = 32'hF; writeEnable = 1'b1;
    addr8 = 2'd0; wd8 = '0; we8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    writeEnable = 1'b0;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      check($sformatf("reset_read_a%0d", a), v, 32'h0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      rd(2'd2, v);
      check("reset_count_idle", v, 32'd0);
    end

    // One-shot, PRESET = 5
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c >= 2 && c <= 7) begin
        rd(2'd2, v);
        check($sformatf("oneshot_count_E%0d", c), v, 32'(7 - c));
      end
      if (c >= 7) check($sformatf("oneshot_irq_E%0d", c), {31'd0, irq}, {31'd0, c == 8});
    end
    rd(2'd0, v);
    check("oneshot_ctrl_en_cleared", v, 32'h8);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("oneshot_irq_held", {31'd0, irq}, 32'd1);
    end
    bus_write(2'd1, 32'd5);
    check("oneshot_irq_cleared_by_preset", {31'd0, irq}, 32'd0);

    // Periodic, PRESET = 3 then 6 written mid-count
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int c = 1; c <= 42; c++) begin
      if (c == 24) bus_write(2'd1, 32'd6);
      else tick();
      exp_irq = (c == 6) || (c == 11) || (c == 16) || (c == 21) ||
                (c == 26) || (c == 34) || (c == 42);
      check($sformatf("periodic_irq_E%0d", c), {31'd0, irq}, {31'd0, exp_irq});
      if (c == 22) begin
        rd(2'd2, v);
        check("periodic_reload_count", v, 32'd3);
      end
      if (c == 27) begin
        rd(2'd2, v);
        check("periodic_new_preset_count", v, 32'd6);
      end
    end
    bus_write(2'd0, 32'h0);
    repeat (3) tick();
    check("periodic_stopped_irq", {31'd0, irq}, 32'd0);

    // Mask: IM = 0 during expiry, then IM set by a write that clears pending
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("mask_irq_E%0d", c), {31'd0, irq}, 32'd0);
    end
    rd(2'd0, v);
    check("mask_ctrl_en_cleared", v, 32'h0);
    bus_write(2'd0, 32'h8);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mask_irq_after_im", {31'd0, irq}, 32'd0);
    end

    // Disable mid-count: count freezes after at most one further decrement
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    for (int c = 1; c <= 15; c++) begin
      if (c == 5) bus_write(2'd0, 32'h8);
      else tick();
      if (c >= 2) begin
        rd(2'd2, v);
        check($sformatf("disable_count_E%0d", c), v, (c <= 5) ? 32'(12 - c) : 32'd7);
      end
      check($sformatf("disable_irq_E%0d", c), {31'd0, irq}, 32'd0);
    end

    // PRESET = 0 and PRESET = 1 both expire with irq after E4
    for (int p = 0; p < 2; p++) begin
      bus_write(2'd1, 32'(p));
      bus_write(2'd0, 32'h9);
      for (int c = 1; c <= 4; c++) begin
        tick();
        check($sformatf("preset%0d_irq_E%0d", p, c), {31'd0, irq}, {31'd0, c == 4});
      end
      bus_write(2'd1, 32'd0);
      check($sformatf("preset%0d_irq_clear", p), {31'd0, irq}, 32'd0);
    end

    // COUNT is read-only, address 3 reads 0, CTRL upper bits ignored
    bus_write(2'd2, 32'h55);
    rd(2'd2, v);
    check("count_write_ignored", v, 32'd0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v);
    check("reserved_reads_zero", v, 32'd0);
    bus_write(2'd0, 32'hFFFF_FFF0);
    rd(2'd0, v);
    check("ctrl_upper_bits_ignored", v, 32'd0);

    // Read in the write cycle returns the pre-write value
    @(negedge clk);
    address = 2'd1; writeData = 32'hAB; writeEnable = 1'b1;
    #1;
    check("read_before_write", readData, 32'd0);
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    check("read_after_write", readData, 32'hAB);

    // 8-bit instance truncates stored PRESET
    @(negedge clk);
    addr8 = 2'd1; wd8 = 32'h1FF; we8 = 1'b1;
    @(posedge clk);
    #1;
    we8 = 1'b0;
    #1;
    check("w8_preset_truncated", rd8, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
